fpdp_division: RTL and testbench

//  IEEE 754 double-precision divider, the counterpart to fpdp_multiplication in the Nth-root datapath.

---
 rtl/fpdp_pkg.sv | 18 +
 rtl/fpdp_mant_divider.sv | 62 ++++++
 rtl/fpdp_division.sv | 118 +++++++++++
 tb/tb_fpdp_division.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/fpdp_pkg.sv
// Shared definitions for the double-precision multiply/divide blocks of the Nth-root datapath.
package fpdp_pkg;

    localparam int          BIAS       = 1023;
    localparam int          QBITS      = 54;
    localparam logic [10:0] EXP_MAX    = 11'h7FF;
    localparam logic [63:0] FPDP_QNAN  = 64'h7FF8_0000_0000_0000;
    localparam logic [63:0] FPDP_PINF  = 64'h7FF0_0000_0000_0000;
    localparam logic [3:0]  READY_REQ  = 4'd1;
    localparam logic [3:0]  DONE_PULSE = 4'd1;

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        NORM
    } fpdp_state_e;

endpackage

// File: rtl/fpdp_mant_divider.sv
// Radix-2 restoring mantissa divider, one quotient bit per clock; q = floor(ma * 2^53 / mb).
module fpdp_mant_divider
    import fpdp_pkg::*;
(
    input  logic             clk,
    input  logic             rset,
    input  logic             start,
    input  logic [52:0]      ma,
    input  logic [52:0]      mb,
    output logic [QBITS-1:0] q,
    output logic             valid
);

    logic [QBITS-1:0] rem_q, rem_d;
    logic [QBITS-1:0] q_q, q_d;
    logic [52:0]      mb_q, mb_d;
    logic [5:0]       cnt_q, cnt_d;
    logic [QBITS-1:0] diff;

    // rem stays below 2*mb, so bit 53 is always clear before the left shift.
    always_comb begin
        diff  = rem_q - {1'b0, mb_q};
        rem_d = rem_q;
        q_d   = q_q;
        mb_d  = mb_q;
        cnt_d = cnt_q;
        if (start) begin
            rem_d = {1'b0, ma};
            mb_d  = mb;
            q_d   = '0;
            cnt_d = 6'(QBITS);
        end else if (cnt_q != 6'd0) begin
            if (rem_q >= {1'b0, mb_q}) begin
                q_d   = {q_q[QBITS-2:0], 1'b1};
                rem_d = {diff[QBITS-2:0], 1'b0};
            end else begin
                q_d   = {q_q[QBITS-2:0], 1'b0};
                rem_d = {rem_q[QBITS-2:0], 1'b0};
            end
            cnt_d = cnt_q - 6'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rset) begin
            rem_q <= '0;
            q_q   <= '0;
            mb_q  <= '0;
            cnt_q <= '0;
        end else begin
            rem_q <= rem_d;
            q_q   <= q_d;
            mb_q  <= mb_d;
            cnt_q <= cnt_d;
        end
    end

    // valid marks the cycle of the final step; q is complete from the next cycle on.
    assign q     = q_q;
    assign valid = (cnt_q == 6'd1);

endmodule

// File: rtl/fpdp_division.sv
// IEEE 754 double divider: special-case decode, sign/exponent path, normalisation and ready/done FSM.
module fpdp_division
    import fpdp_pkg::*;
(
    input  logic        clk,
    input  logic        rset,
    input  logic [63:0] fpdp_dividend,
    input  logic [63:0] fpdp_divisor,
    input  logic [3:0]  ready,
    output logic [63:0] fpdp_quotient,
    output logic [3:0]  done,
    output logic        busy
);

    fpdp_state_e        state_q, state_d;
    logic               sign_q, sign_d;
    logic signed [12:0] ebase_q, ebase_d;
    logic               spec_q, spec_d;
    logic [63:0]        sres_q, sres_d;
    logic [63:0]        quot_q, quot_d;
    logic [3:0]         done_q, done_d;
    logic               busy_q, busy_d;

    logic               a_zero, b_zero, special, sign_in, accept, mstart, mvalid;
    logic [63:0]        sres_in, norm_res;
    logic [QBITS-1:0]   mq;
    logic signed [12:0] e;
    logic [51:0]        frac;

    assign a_zero  = (fpdp_dividend[62:52] == 11'd0);
    assign b_zero  = (fpdp_divisor[62:52] == 11'd0);
    assign special = a_zero | b_zero;
    assign sign_in = fpdp_dividend[63] ^ fpdp_divisor[63];
    assign accept  = (state_q == IDLE) && (ready == READY_REQ);
    assign mstart  = accept && !special;

    always_comb begin
        if (a_zero && b_zero) sres_in = FPDP_QNAN;
        else if (b_zero)      sres_in = {sign_in, EXP_MAX, 52'd0};
        else                  sres_in = 64'd0;
    end

    fpdp_mant_divider u_mdiv (
        .clk   (clk),
        .rset  (rset),
        .start (mstart),
        .ma    ({1'b1, fpdp_dividend[51:0]}),
        .mb    ({1'b1, fpdp_divisor[51:0]}),
        .q     (mq),
        .valid (mvalid)
    );

    // Quotient lies in (0.5, 2): a clear integer bit costs one exponent step.
    always_comb begin
        frac = mq[53] ? mq[52:1] : mq[51:0];
        e    = ebase_q - $signed({12'd0, ~mq[53]});
        if (e >= 13'sd2047)  norm_res = {sign_q, EXP_MAX, 52'd0};
        else if (e <= 13'sd0) norm_res = {sign_q, 63'd0};
        else                  norm_res = {sign_q, e[10:0], frac};
    end

    always_comb begin
        state_d = state_q;
        sign_d  = sign_q;
        ebase_d = ebase_q;
        spec_d  = spec_q;
        sres_d  = sres_q;
        quot_d  = quot_q;
        done_d  = 4'd0;
        busy_d  = busy_q;
        case (state_q)
            IDLE: if (accept) begin
                busy_d  = 1'b1;
                sign_d  = sign_in;
                ebase_d = $signed({2'b00, fpdp_dividend[62:52]}) - $signed({2'b00, fpdp_divisor[62:52]})
                          + $signed(13'(BIAS));
                spec_d  = special;
                sres_d  = sres_in;
                state_d = special ? NORM : DIV;
            end
            DIV: if (mvalid) state_d = NORM;
            NORM: begin
                quot_d  = spec_q ? sres_q : norm_res;
                done_d  = DONE_PULSE;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rset) begin
            state_q <= IDLE;
            sign_q  <= 1'b0;
            ebase_q <= '0;
            spec_q  <= 1'b0;
            sres_q  <= '0;
            quot_q  <= '0;
            done_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sign_q  <= sign_d;
            ebase_q <= ebase_d;
            spec_q  <= spec_d;
            sres_q  <= sres_d;
            quot_q  <= quot_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign fpdp_quotient = quot_q;
    assign done          = done_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_fpdp_division.sv
// Scoreboard bench for fpdp_division: driver pushes expected result and done edge, monitor pops on done.
module tb_fpdp_division;

    logic        clk = 1'b0;
    logic        rset;
    logic [63:0] fpdp_dividend, fpdp_divisor, fpdp_quotient;
    logic [3:0]  ready, done;
    logic        busy;

    fpdp_division dut (
        .clk           (clk),
        .rset          (rset),
        .fpdp_dividend (fpdp_dividend),
        .fpdp_divisor  (fpdp_divisor),
        .ready         (ready),
        .fpdp_quotient (fpdp_quotient),
        .done          (done),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass = 0;
    int n_total = 0;

    typedef struct {
        logic [63:0] val;
        int          at;
    } exp_t;
    exp_t sb[$];

    task automatic check64(input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_total++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %h expected %h (edge %0d)", nm, act, expv, cyc);
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    exp_t cur;
    always @(negedge clk) begin
        if (!rset && done != 4'd0) begin
            if (sb.size() == 0) begin
                n_total++;
                $display("FAIL spurious_done: done=%0d with nothing outstanding (edge %0d)", done, cyc);
            end else begin
                cur = sb.pop_front();
                check64("done_value", 64'(done), 64'd1);
                check64("quotient", fpdp_quotient, cur.val);
                check64("done_edge", 64'(cyc), 64'(cur.at));
            end
        end
    end

    task automatic wait_done(input int maxc);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < maxc && !seen; i++) begin
            @(negedge clk);
            if (done != 4'd0) seen = 1'b1;
        end
        if (!seen) begin
            n_total++;
            $display("FAIL done_timeout: no done within %0d cycles", maxc);
            sb.delete();
        end
    endtask

    task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic [63:0] expv,
                          input int lat, input bit poke);
        @(negedge clk);
        fpdp_dividend = a;
        fpdp_divisor  = b;
        ready         = 4'd1;
        sb.push_back('{val: expv, at: cyc + 1 + lat});
        @(negedge clk);
        ready         = 4'd0;
        fpdp_dividend = 64'h4059_0000_0000_0000;
        fpdp_divisor  = 64'h4024_0000_0000_0000;
        check64("busy_after_accept", 64'(busy), 64'd1);
        if (poke) begin
            repeat (8) @(negedge clk);
            ready = 4'd1;
            @(negedge clk);
            ready = 4'd0;
        end
        wait_done(80);
        check64("busy_after_done", 64'(busy), 64'd0);
    endtask

    localparam int NV = 10;
    logic [63:0] va[NV], vb[NV], ve[NV];
    int          vl[NV];

    initial begin
        va[0] = 64'h4018000000000000; vb[0] = 64'h4000000000000000; ve[0] = 64'h4008000000000000; vl[0] = 55;
        va[1] = 64'h3FF0000000000000; vb[1] = 64'h4008000000000000; ve[1] = 64'h3FD5555555555555; vl[1] = 55;
        va[2] = 64'hBFF8000000000000; vb[2] = 64'h3FE0000000000000; ve[2] = 64'hC008000000000000; vl[2] = 55;
        va[3] = 64'h3FF0000000000000; vb[3] = 64'h0000000000000000; ve[3] = 64'h7FF0000000000000; vl[3] = 1;
        va[4] = 64'h0000000000000000; vb[4] = 64'h0000000000000000; ve[4] = 64'h7FF8000000000000; vl[4] = 1;
        va[5] = 64'h0000000000000000; vb[5] = 64'h4014000000000000; ve[5] = 64'h0000000000000000; vl[5] = 1;
        va[6] = 64'hBFF0000000000000; vb[6] = 64'h0000000000000000; ve[6] = 64'hFFF0000000000000; vl[6] = 1;
        va[7] = 64'h000FFFFFFFFFFFFF; vb[7] = 64'h4000000000000000; ve[7] = 64'h0000000000000000; vl[7] = 1;
        va[8] = 64'h0010000000000000; vb[8] = 64'h4000000000000000; ve[8] = 64'h0000000000000000; vl[8] = 55;
        va[9] = 64'h7FE0000000000000; vb[9] = 64'h0010000000000000; ve[9] = 64'h7FF0000000000000; vl[9] = 55;
    end

    initial begin
        int n0;
        rset          = 1'b1;
        ready         = 4'd0;
        fpdp_dividend = '0;
        fpdp_divisor  = '0;
        repeat (3) @(negedge clk);
        check64("reset_quotient", fpdp_quotient, 64'd0);
        check64("reset_done", 64'(done), 64'd0);
        check64("reset_busy", 64'(busy), 64'd0);
        rset = 1'b0;

        for (int i = 0; i < NV; i++) run_op(va[i], vb[i], ve[i], vl[i], i == 0);

        // Abort a 6.0/2.0 with reset on edge 20 after accept.
        @(negedge clk);
        fpdp_dividend = 64'h4018000000000000;
        fpdp_divisor  = 64'h4000000000000000;
        ready         = 4'd1;
        @(negedge clk);
        ready = 4'd0;
        repeat (19) @(negedge clk);
        rset = 1'b1;
        @(negedge clk);
        rset = 1'b0;
        check64("abort_quotient", fpdp_quotient, 64'd0);
        check64("abort_done", 64'(done), 64'd0);
        check64("abort_busy", 64'(busy), 64'd0);
        repeat (70) @(negedge clk);
        run_op(64'h4018000000000000, 64'h4000000000000000, 64'h4008000000000000, 55, 1'b0);

        // Back-to-back: ready held high across three operations.
        @(negedge clk);
        n0            = cyc;
        fpdp_dividend = va[0];
        fpdp_divisor  = vb[0];
        ready         = 4'd1;
        for (int k = 0; k < 3; k++) begin
            sb.push_back('{val: ve[k], at: n0 + 1 + 55 + 56 * k});
            wait_done(70);
            if (k < 2) begin
                fpdp_dividend = va[k + 1];
                fpdp_divisor  = vb[k + 1];
            end else begin
                ready = 4'd0;
            end
        end

        repeat (70) @(negedge clk);
        if (sb.size() != 0) begin
            n_total++;
            $display("FAIL leftover_expectations: %0d outstanding, expected 0", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
